axi_mon_wr_id_tracker: RTL

//  Write-side ID tracker/scheduler for the AXI monitor. Remaps external AW IDs (AxiIdWidth) onto

---
 rtl/slv_pkg.sv | 27 ++
 rtl/axi_mon_id_slot.sv | 81 ++++++++
 rtl/axi_mon_wr_id_tracker.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/slv_pkg.sv
// Shared constants and types for the AXI monitor write-ID tracker.
// Defines ID widths, slot-state layout and derived counter widths.
package slv_pkg;

    localparam int unsigned MaxUniqIds    = 32;
    localparam int unsigned MaxTxnsPerId  = 1;
    localparam int unsigned CntWidth      = 10;
    localparam int unsigned PrescalerDiv  = 1;
    localparam int unsigned AxiIdWidth    = 6;
    localparam int unsigned AxiIntIdWidth = (MaxUniqIds > 1) ? $clog2(MaxUniqIds) : 1;
    localparam int unsigned TxnCntWidth   = $clog2(MaxTxnsPerId + 1);
    localparam int unsigned OutstWidth    = $clog2(MaxUniqIds + 1);

    typedef logic [AxiIdWidth-1:0]    id_t;
    typedef logic [AxiIntIdWidth-1:0] intid_t;
    typedef logic [TxnCntWidth-1:0]   txn_cnt_t;
    typedef logic [CntWidth-1:0]      timer_t;

    typedef struct packed {
        logic     valid;
        id_t      id;
        txn_cnt_t cnt;
        timer_t   timer;
        logic     expired;
    } slot_state_t;

endpackage

// File: rtl/axi_mon_id_slot.sv
// One internal-ID slot: outstanding count, stored external ID, timeout timer
// and the sticky expired / pending-report flags.
module axi_mon_id_slot
    import slv_pkg::*;
(
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      alloc_i,
    input  logic                      free_i,
    input  logic                      tick_i,
    input  logic                      clear_i,
    input  logic                      report_i,
    input  logic [AxiIdWidth-1:0]     aw_id_i,
    input  logic [CntWidth-1:0]       budget_i,
    output logic                      valid_o,
    output logic [AxiIdWidth-1:0]     id_o,
    output logic                      full_o,
    output logic                      pending_o
);

    slot_state_t r_state;
    slot_state_t w_state_nxt;
    logic        r_pending;
    logic        w_pending_nxt;
    logic        w_last;
    logic        w_expire;

    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending;
        w_last   = free_i & ~alloc_i & (r_state.cnt == txn_cnt_t'(1));
        // A handshake restarts the timer, so it cannot expire in that same cycle.
        w_expire = tick_i & r_state.valid & ~r_state.expired & (r_state.timer == '0)
                 & ~alloc_i & ~free_i;

        if (alloc_i) begin
            w_state_nxt.valid = 1'b1;
            w_state_nxt.id    = aw_id_i;
        end

        if (alloc_i && !free_i)
            w_state_nxt.cnt = r_state.cnt + txn_cnt_t'(1);
        else if (free_i && !alloc_i)
            w_state_nxt.cnt = r_state.cnt - txn_cnt_t'(1);

        if (alloc_i || free_i)
            w_state_nxt.timer = budget_i;
        else if (tick_i && r_state.valid && !r_state.expired && r_state.timer != '0)
            w_state_nxt.timer = r_state.timer - timer_t'(1);

        if (w_last) begin
            w_state_nxt.valid   = 1'b0;
            w_state_nxt.expired = 1'b0;
        end else if (w_expire) begin
            w_state_nxt.expired = 1'b1;
        end else if (clear_i) begin
            w_state_nxt.expired = 1'b0;
        end

        if (w_expire)
            w_pending_nxt = 1'b1;
        else if (report_i)
            w_pending_nxt = 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= '0;
            r_pending <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
        end
    end

    assign valid_o   = r_state.valid;
    assign id_o      = r_state.id;
    assign full_o    = (r_state.cnt >= txn_cnt_t'(MaxTxnsPerId));
    assign pending_o = r_pending;

endmodule

// File: rtl/axi_mon_wr_id_tracker.sv
// Write-side ID tracker: remaps AW IDs onto internal slots, stalls AW when no
// slot is usable, restores IDs on B and reports per-slot timeouts.
module axi_mon_wr_id_tracker #(
    parameter int unsigned PrescalerDiv = slv_pkg::PrescalerDiv
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              enable_i,
    input  logic [slv_pkg::CntWidth-1:0]      budget_i,
    input  logic                              clear_i,
    input  logic                              aw_valid_i,
    input  logic [slv_pkg::AxiIdWidth-1:0]    aw_id_i,
    output logic                              aw_ready_o,
    output logic                              aw_valid_o,
    input  logic                              aw_ready_i,
    output logic [slv_pkg::AxiIntIdWidth-1:0] aw_intid_o,
    input  logic                              b_valid_i,
    input  logic                              b_ready_i,
    input  logic [slv_pkg::AxiIntIdWidth-1:0] b_intid_i,
    output logic [slv_pkg::AxiIdWidth-1:0]    b_id_o,
    output logic                              timeout_o,
    output logic [slv_pkg::AxiIntIdWidth-1:0] timeout_intid_o,
    output logic [slv_pkg::AxiIdWidth-1:0]    timeout_id_o,
    output logic                              err_o,
    output logic [slv_pkg::OutstWidth-1:0]    outstanding_o
);
    import slv_pkg::*;

    localparam int unsigned PW = (PrescalerDiv > 1) ? $clog2(PrescalerDiv) : 1;

    logic [PW-1:0]         r_presc;
    logic                  w_tick;
    logic [MaxUniqIds-1:0] w_valid;
    logic [MaxUniqIds-1:0] w_full;
    logic [MaxUniqIds-1:0] w_pending;
    logic [MaxUniqIds-1:0] w_alloc;
    logic [MaxUniqIds-1:0] w_free;
    logic [MaxUniqIds-1:0] w_report;
    id_t                   w_id [MaxUniqIds];

    intid_t                w_match_idx;
    intid_t                w_free_idx;
    intid_t                w_pend_idx;
    intid_t                w_chosen;
    logic                  w_any_match;
    logic                  w_any_free;
    logic                  w_any_pend;
    logic                  w_usable;
    logic                  w_aw_hs;
    logic                  w_b_hs;
    logic [OutstWidth-1:0] w_outst;

    logic                  r_timeout;
    intid_t                r_timeout_intid;
    id_t                   r_timeout_id;
    logic                  r_err;

    // Descending scan so the lowest matching/free/pending index is what remains.
    always_comb begin
        w_match_idx = '0;
        w_free_idx  = '0;
        w_pend_idx  = '0;
        w_any_match = 1'b0;
        w_any_free  = 1'b0;
        w_any_pend  = 1'b0;
        w_outst     = '0;
        for (int i = MaxUniqIds - 1; i >= 0; i--) begin
            if (w_valid[i] && (w_id[i] == aw_id_i)) begin
                w_match_idx = intid_t'(i);
                w_any_match = 1'b1;
            end
            if (!w_valid[i]) begin
                w_free_idx = intid_t'(i);
                w_any_free = 1'b1;
            end
            if (w_pending[i]) begin
                w_pend_idx = intid_t'(i);
                w_any_pend = 1'b1;
            end
            w_outst = w_outst + OutstWidth'(w_valid[i]);
        end
        // A full matching slot stalls so per-ID ordering is kept.
        w_chosen = w_any_match ? w_match_idx : w_free_idx;
        w_usable = w_any_match ? ~w_full[w_match_idx] : w_any_free;
    end

    assign aw_valid_o = aw_valid_i & w_usable & ~rst_i;
    assign aw_ready_o = aw_ready_i & w_usable & ~rst_i;
    assign aw_intid_o = w_usable ? w_chosen : '0;
    assign w_aw_hs    = aw_valid_o & aw_ready_i;
    assign w_b_hs     = b_valid_i & b_ready_i;
    assign b_id_o     = w_id[b_intid_i];
    assign w_tick     = enable_i & (r_presc == PW'(PrescalerDiv - 1));

    for (genvar g = 0; g < MaxUniqIds; g++) begin : g_slot
        assign w_alloc[g]  = w_aw_hs & (w_chosen == intid_t'(g));
        assign w_free[g]   = w_b_hs & w_valid[g] & (b_intid_i == intid_t'(g));
        assign w_report[g] = w_any_pend & (w_pend_idx == intid_t'(g));

        axi_mon_id_slot u_slot (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .alloc_i   (w_alloc[g]),
            .free_i    (w_free[g]),
            .tick_i    (w_tick),
            .clear_i   (clear_i),
            .report_i  (w_report[g]),
            .aw_id_i   (aw_id_i),
            .budget_i  (budget_i),
            .valid_o   (w_valid[g]),
            .id_o      (w_id[g]),
            .full_o    (w_full[g]),
            .pending_o (w_pending[g])
        );
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_presc <= '0;
        end else if (!enable_i || w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_timeout       <= 1'b0;
            r_timeout_intid <= '0;
            r_timeout_id    <= '0;
            r_err           <= 1'b0;
        end else begin
            r_timeout       <= w_any_pend;
            r_timeout_intid <= w_any_pend ? w_pend_idx : '0;
            r_timeout_id    <= w_any_pend ? w_id[w_pend_idx] : '0;
            r_err           <= w_b_hs & ~w_valid[b_intid_i];
        end
    end

    assign timeout_o       = r_timeout;
    assign timeout_intid_o = r_timeout_intid;
    assign timeout_id_o    = r_timeout_id;
    assign err_o           = r_err;
    assign outstanding_o   = w_outst;

endmodule
